up_down_counter_bounded: RTL and testbench
==========================================

// Module: up_down_counter_bounded
// PURPOSE
//  Parametrised up/down counter with programmable step, bounds [min_value,max_value], load,
//  and wrap or saturate mode at the bounds. Reports bound hits as 1-cycle pulses and sticky
//  flags. Used for button-driven and event-driven counters in the board designs.
// PARAMETERS
//  WIDTH        8  count, bound and load width in bits
//  STEP_W       4  step input width (unsigned)
//  SATURATE     0  0: wrap to opposite bound on overflow/underflow; 1: clamp at bound
//  RESET_VALUE  0  count after reset (WIDTH bits, not clamped)
// PORTS
//  clock        in   1        clock; all state updates on posedge
//  reset        in   1        reset, synchronous, active-high
//  enable       in   1        count-step qualifier
//  up           in   1        count-up request
//  down         in   1        count-down request
//  step         in   STEP_W   increment/decrement magnitude
//  load         in   1        load load_value (clamped) into count
//  load_value   in   WIDTH    value to load
//  min_value    in   WIDTH    lower bound, inclusive
//  max_value    in   WIDTH    upper bound, inclusive
//  clear_flags  in   1        clear ovf_sticky/unf_sticky
//  count        out  WIDTH    current count (registered)
//  at_max       out  1        count == max_value (combinational from count)
//  at_min       out  1        count == min_value (combinational from count)
//  ovf_pulse    out  1        registered; high 1 cycle after an overflowing step
//  unf_pulse    out  1        registered; high 1 cycle after an underflowing step
//  ovf_sticky   out  1        set by overflow, held until clear_flags
//  unf_sticky   out  1        set by underflow, held until clear_flags
//  cfg_err      out  1        min_value > max_value (combinational)
// BEHAVIOUR
//  - Reset: count=RESET_VALUE; ovf_pulse, unf_pulse, ovf_sticky, unf_sticky = 0.
//    Reset overrides all other inputs in the same cycle.
//  - Priority per cycle: reset > load > step > hold.
//  - load: count <= clamp(load_value, min_value, max_value). No pulses. Ignores enable.
//  - Step op occurs iff enable & (up ^ down) & step!=0 & !load & !cfg_err; else count holds.
//  - up&down both high, or step==0: hold, no pulses.
//  - Arithmetic in WIDTH+1 bits, zero-extended step; no silent modular wrap of the width.
//  - Up: s = count + step.
//    s <= max_value: count <= s.
//    s > max_value: overflow. SATURATE=0: count <= min_value. SATURATE=1: count <= max_value.
//    Remainder is discarded.
//  - Down: d = count - step, signed WIDTH+1.
//    d >= min_value: count <= d.
//    Otherwise underflow. SATURATE=0: count <= max_value. SATURATE=1: count <= min_value.
//  - In saturate mode, stepping while already at the bound still counts as overflow/underflow.
//  - count outside [min,max] after a bounds change: the next step op applies the same rules.
//    For example, count>max on an up step -> overflow.
//  - Pulses: ovf_pulse/unf_pulse are registered in the same edge as the count update.
//    They are high for exactly the cycle following the event; back-to-back events keep them high.
//  - Sticky: set on event, cleared by clear_flags. Set wins when an event and clear_flags
//    coincide.
//  - cfg_err=1: step ops are suppressed; load still clamps via max(min_value, min(load_value, max_value)),
//    i.e. yields min_value.
//  - Latency: count, pulses and stickies update 1 clock after the qualifying edge.
//    at_max, at_min and cfg_err have zero latency.
// TESTING
//  1 WIDTH=8,SAT=0,min=0,max=9,step=1: 10 up ops from 0 -> 1..9,0. ovf_pulse once after the 10th;
//    ovf_sticky=1.
//  2 SAT=1,min=2,max=200,count=198,step=5 up -> 200, ovf_pulse; up again -> 200, ovf_pulse again.
//  3 min=10,max=50,count=12,step=4 down -> 10? no: 12-4=8<10 -> unf. SAT=0: 50; SAT=1: 10.
//    unf_sticky=1.
//  4 up=down=1, step=0, or enable=0 -> count holds, no pulses. load=1 with load_value=255, max=50
//    -> 50, no pulse.
//  5 reset high mid-run with load and up active -> count=RESET_VALUE and all flags 0 the next cycle.
//  6 clear_flags coincident with overflow -> ovf_sticky stays 1; clear_flags alone next cycle -> 0.
//    min=60,max=40 -> cfg_err=1, up ops hold count.

Source files
------------

// File: rtl/up_down_counter_bounded.sv
// Bounded up/down counter with programmable step, clamped load and wrap/saturate handling
// at the bounds; bound hits are reported as registered pulses and sticky flags.
module up_down_counter_bounded #(
    parameter int               WIDTH       = 8,
    parameter int               STEP_W      = 4,
    parameter int               SATURATE    = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              up,
    input  logic              down,
    input  logic [STEP_W-1:0] step,
    input  logic              load,
    input  logic [WIDTH-1:0]  load_value,
    input  logic [WIDTH-1:0]  min_value,
    input  logic [WIDTH-1:0]  max_value,
    input  logic              clear_flags,
    output logic [WIDTH-1:0]  count,
    output logic              at_max,
    output logic              at_min,
    output logic              ovf_pulse,
    output logic              unf_pulse,
    output logic              ovf_sticky,
    output logic              unf_sticky,
    output logic              cfg_err
);

    // Two guard bits: one for the carry of an up step, one as the sign of a down step.
    localparam int EXT_W = WIDTH + 2;

    function automatic logic [WIDTH-1:0] clamp_fn(
        input logic [WIDTH-1:0] value,
        input logic [WIDTH-1:0] lo,
        input logic [WIDTH-1:0] hi
    );
        logic [WIDTH-1:0] upper_s;
        upper_s = (value > hi) ? hi : value;
        return (upper_s < lo) ? lo : upper_s;
    endfunction

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             ovf_pulse_r;
    logic             unf_pulse_r;
    logic             ovf_sticky_r;
    logic             unf_sticky_r;
    logic             cfg_err_s;
    logic             step_op_s;
    logic             ovf_event_s;
    logic             unf_event_s;
    logic [EXT_W-1:0] step_ext_s;
    logic [EXT_W-1:0] up_sum_s;
    logic [EXT_W-1:0] down_diff_s;
    logic             up_over_s;
    logic             down_under_s;

    assign cfg_err_s  = (min_value > max_value);
    assign step_op_s  = enable & (up ^ down) & (step != {STEP_W{1'b0}}) & ~load & ~cfg_err_s;

    assign step_ext_s  = EXT_W'(step);
    assign up_sum_s    = EXT_W'(count_r) + step_ext_s;
    assign down_diff_s = EXT_W'(count_r) - step_ext_s;

    // A negative difference sets the top bit, which must not be mistaken for a large value.
    assign up_over_s    = (up_sum_s > EXT_W'(max_value));
    assign down_under_s = down_diff_s[EXT_W-1] | (down_diff_s < EXT_W'(min_value));

    // Next count and bound events: load beats a step, otherwise hold.
    always_comb begin
        count_next_s = count_r;
        ovf_event_s  = 1'b0;
        unf_event_s  = 1'b0;
        if (load) begin
            count_next_s = clamp_fn(load_value, min_value, max_value);
        end else if (step_op_s) begin
            if (up) begin
                if (up_over_s) begin
                    ovf_event_s  = 1'b1;
                    count_next_s = (SATURATE != 0) ? max_value : min_value;
                end else begin
                    count_next_s = up_sum_s[WIDTH-1:0];
                end
            end else begin
                if (down_under_s) begin
                    unf_event_s  = 1'b1;
                    count_next_s = (SATURATE != 0) ? min_value : max_value;
                end else begin
                    count_next_s = down_diff_s[WIDTH-1:0];
                end
            end
        end else begin
            count_next_s = count_r;
        end
    end

    // Count and one-cycle event pulses, updated on the same edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_r     <= RESET_VALUE;
            ovf_pulse_r <= 1'b0;
            unf_pulse_r <= 1'b0;
        end else begin
            count_r     <= count_next_s;
            ovf_pulse_r <= ovf_event_s;
            unf_pulse_r <= unf_event_s;
        end
    end

    // Sticky flags: a new event wins over a coincident clear.
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf_sticky_r <= 1'b0;
            unf_sticky_r <= 1'b0;
        end else begin
            if (ovf_event_s) begin
                ovf_sticky_r <= 1'b1;
            end else if (clear_flags) begin
                ovf_sticky_r <= 1'b0;
            end
            if (unf_event_s) begin
                unf_sticky_r <= 1'b1;
            end else if (clear_flags) begin
                unf_sticky_r <= 1'b0;
            end
        end
    end

    assign count      = count_r;
    assign at_max     = (count_r == max_value);
    assign at_min     = (count_r == min_value);
    assign ovf_pulse  = ovf_pulse_r;
    assign unf_pulse  = unf_pulse_r;
    assign ovf_sticky = ovf_sticky_r;
    assign unf_sticky = unf_sticky_r;
    assign cfg_err    = cfg_err_s;

endmodule

// File: tb/tb_up_down_counter_bounded.sv
// Bench for up_down_counter_bounded: a wrapping and a saturating instance share stimulus;
// a queue-based scoreboard carries expected values from drive time to the sampling point.
module tb_up_down_counter_bounded;

    logic       clock = 1'b0;
    logic       reset, enable, up, down, load, clear_flags;
    logic [3:0] step;
    logic [7:0] load_value, min_value, max_value;

    logic [7:0] cnt  [2];
    logic       amax [2];
    logic       amin [2];
    logic       ovp  [2];
    logic       unp  [2];
    logic       ovs  [2];
    logic       uns  [2];
    logic       cerr [2];

    int checks = 0;
    int errors = 0;

    localparam int RV   [2] = '{0, 250};
    localparam int SATS [2] = '{0, 1};

    always #5 clock = ~clock;

    up_down_counter_bounded #(.WIDTH(8), .STEP_W(4), .SATURATE(0), .RESET_VALUE(8'd0)) dut_wrap (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .down(down), .step(step),
        .load(load), .load_value(load_value), .min_value(min_value), .max_value(max_value),
        .clear_flags(clear_flags), .count(cnt[0]), .at_max(amax[0]), .at_min(amin[0]),
        .ovf_pulse(ovp[0]), .unf_pulse(unp[0]), .ovf_sticky(ovs[0]), .unf_sticky(uns[0]),
        .cfg_err(cerr[0]));

    up_down_counter_bounded #(.WIDTH(8), .STEP_W(4), .SATURATE(1), .RESET_VALUE(8'd250)) dut_sat (
        .clock(clock), .reset(reset), .enable(enable), .up(up), .down(down), .step(step),
        .load(load), .load_value(load_value), .min_value(min_value), .max_value(max_value),
        .clear_flags(clear_flags), .count(cnt[1]), .at_max(amax[1]), .at_min(amin[1]),
        .ovf_pulse(ovp[1]), .unf_pulse(unp[1]), .ovf_sticky(ovs[1]), .unf_sticky(uns[1]),
        .cfg_err(cerr[1]));

    typedef struct {
        string          tag;
        logic [1:0][7:0] c;
        logic [1:0]     op;
        logic [1:0]     uq;
        logic [1:0]     os;
        logic [1:0]     us;
    } exp_t;

    exp_t sb[$];
    int   mc  [2];
    bit   mos [2];
    bit   mus [2];

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", name, obs, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic, evaluated with the inputs being driven.
    task automatic predict(inout exp_t e, input int i);
        int  c, mn, mx, s, lv;
        bit  o, u;
        c  = mc[i];
        mn = min_value;
        mx = max_value;
        s  = step;
        lv = load_value;
        o  = 1'b0;
        u  = 1'b0;
        if (reset) begin
            c      = RV[i];
            mos[i] = 1'b0;
            mus[i] = 1'b0;
        end else begin
            if (load) begin
                c = lv;
                if (c > mx) c = mx;
                if (c < mn) c = mn;
            end else if (enable && (up != down) && s != 0 && mn <= mx) begin
                if (up) begin
                    if (c + s > mx) begin o = 1'b1; c = (SATS[i] != 0) ? mx : mn; end
                    else c = c + s;
                end else begin
                    if (c - s < mn) begin u = 1'b1; c = (SATS[i] != 0) ? mn : mx; end
                    else c = c - s;
                end
            end
            if (o) mos[i] = 1'b1; else if (clear_flags) mos[i] = 1'b0;
            if (u) mus[i] = 1'b1; else if (clear_flags) mus[i] = 1'b0;
        end
        mc[i]   = c;
        e.c[i]  = 8'(c);
        e.op[i] = o;
        e.uq[i] = u;
        e.os[i] = mos[i];
        e.us[i] = mus[i];
    endtask

    // One clock: push the prediction for the driven inputs, then pop and compare after the edge.
    task automatic cycle(input string tag);
        exp_t e;
        exp_t g;
        e.tag = tag;
        for (int i = 0; i < 2; i++) predict(e, i);
        sb.push_back(e);
        @(posedge clock);
        #1;
        g = sb.pop_front();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s/d%0d/count", g.tag, i), 32'(cnt[i]), 32'(g.c[i]));
            chk($sformatf("%s/d%0d/ovf_pulse", g.tag, i), 32'(ovp[i]), 32'(g.op[i]));
            chk($sformatf("%s/d%0d/unf_pulse", g.tag, i), 32'(unp[i]), 32'(g.uq[i]));
            chk($sformatf("%s/d%0d/ovf_sticky", g.tag, i), 32'(ovs[i]), 32'(g.os[i]));
            chk($sformatf("%s/d%0d/unf_sticky", g.tag, i), 32'(uns[i]), 32'(g.us[i]));
            chk($sformatf("%s/d%0d/at_max", g.tag, i), 32'(amax[i]), 32'(mc[i] == int'(max_value)));
            chk($sformatf("%s/d%0d/at_min", g.tag, i), 32'(amin[i]), 32'(mc[i] == int'(min_value)));
            chk($sformatf("%s/d%0d/cfg_err", g.tag, i), 32'(cerr[i]), 32'(min_value > max_value));
        end
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; up = 1'b0; down = 1'b0; step = 4'd1;
        load = 1'b0; load_value = 8'd0; min_value = 8'd0; max_value = 8'd9; clear_flags = 1'b0;
        #1;
        cycle("reset");
        cycle("reset_hold");
        chk("rst_count_wrap", 32'(cnt[0]), 32'd0);
        chk("rst_count_sat_unclamped", 32'(cnt[1]), 32'd250);
        chk("rst_flags", 32'({ovp[0], unp[0], ovs[0], uns[0], ovp[1], unp[1], ovs[1], uns[1]}), 32'd0);

        // Ten unit up steps over 0..9 on the wrapping instance.
        reset = 1'b0; enable = 1'b1; up = 1'b1;
        for (int k = 0; k < 9; k++) cycle("t1_up");
        chk("t1_count9", 32'(cnt[0]), 32'd9);
        chk("t1_no_pulse_yet", 32'(ovp[0]), 32'd0);
        cycle("t1_up10");
        chk("t1_wrap_to_min", 32'(cnt[0]), 32'd0);
        chk("t1_pulse", 32'(ovp[0]), 32'd1);
        chk("t1_sticky", 32'(ovs[0]), 32'd1);
        enable = 1'b0;
        cycle("t1_idle");
        chk("t1_pulse_drop", 32'(ovp[0]), 32'd0);

        // Saturate at 200, then step again while pinned at the bound.
        min_value = 8'd2; max_value = 8'd200; load = 1'b1; load_value = 8'd198;
        cycle("t2_load");
        load = 1'b0; enable = 1'b1; up = 1'b1; step = 4'd5;
        cycle("t2_up1");
        chk("t2_sat_count", 32'(cnt[1]), 32'd200);
        chk("t2_sat_pulse", 32'(ovp[1]), 32'd1);
        chk("t2_wrap_count", 32'(cnt[0]), 32'd2);
        cycle("t2_up2");
        chk("t2_sat_again", 32'(cnt[1]), 32'd200);
        chk("t2_sat_pulse_again", 32'(ovp[1]), 32'd1);

        // Down step crossing the lower bound.
        min_value = 8'd10; max_value = 8'd50; load = 1'b1; load_value = 8'd12; enable = 1'b0;
        cycle("t3_load");
        load = 1'b0; enable = 1'b1; up = 1'b0; down = 1'b1; step = 4'd4;
        cycle("t3_down");
        chk("t3_wrap_to_max", 32'(cnt[0]), 32'd50);
        chk("t3_sat_to_min", 32'(cnt[1]), 32'd10);
        chk("t3_unf_sticky", 32'({uns[0], uns[1]}), 32'd3);

        // Hold conditions and an out-of-range load.
        up = 1'b1; down = 1'b1;
        cycle("t4_both");
        down = 1'b0; step = 4'd0;
        cycle("t4_step0");
        step = 4'd1; enable = 1'b0;
        cycle("t4_disabled");
        chk("t4_hold", 32'({cnt[0], cnt[1]}), 32'({8'd50, 8'd10}));
        load = 1'b1; load_value = 8'd255;
        cycle("t4_load_clamp");
        chk("t4_load_max", 32'({cnt[0], cnt[1]}), 32'({8'd50, 8'd50}));
        chk("t4_load_no_pulse", 32'({ovp[0], ovp[1]}), 32'd0);

        // Overflow coinciding with clear, then clear alone.
        load = 1'b0; enable = 1'b1; up = 1'b1; step = 4'd1; clear_flags = 1'b1;
        cycle("t6_ovf_clear");
        chk("t6_set_wins", 32'({ovs[0], ovs[1]}), 32'd3);
        enable = 1'b0;
        cycle("t6_clear");
        chk("t6_cleared", 32'({ovs[0], ovs[1], uns[0], uns[1]}), 32'd0);
        clear_flags = 1'b0;

        // Arithmetic beyond the 8-bit range in both directions.
        min_value = 8'd0; max_value = 8'd255; load = 1'b1; load_value = 8'd250;
        cycle("bnd_load");
        load = 1'b0; enable = 1'b1; up = 1'b1; step = 4'd10;
        cycle("bnd_up_carry");
        chk("bnd_carry_sat", 32'(cnt[1]), 32'd255);
        chk("bnd_carry_wrap", 32'(cnt[0]), 32'd0);
        load = 1'b1; load_value = 8'd3;
        cycle("bnd_load3");
        load = 1'b0; up = 1'b0; down = 1'b1; step = 4'd5;
        cycle("bnd_down_neg");
        chk("bnd_neg_wrap", 32'(cnt[0]), 32'd255);
        chk("bnd_neg_sat", 32'(cnt[1]), 32'd0);

        // Inverted bounds suppress steps; load yields min.
        min_value = 8'd60; max_value = 8'd40; up = 1'b1; down = 1'b0; step = 4'd3;
        #1;
        chk("cfg_err_comb", 32'({cerr[0], cerr[1]}), 32'd3);
        cycle("cfg_up1");
        cycle("cfg_up2");
        chk("cfg_hold", 32'({cnt[0], cnt[1]}), 32'({8'd255, 8'd0}));
        load = 1'b1; load_value = 8'd255;
        cycle("cfg_load");
        chk("cfg_load_min", 32'({cnt[0], cnt[1]}), 32'({8'd60, 8'd60}));
        load = 1'b0;

        // Randomised traffic over small, occasionally inverted ranges.
        for (int k = 0; k < 80; k++) begin
            if (k % 8 == 0) begin
                min_value = 8'($urandom_range(0, 30));
                max_value = 8'($urandom_range(20, 60));
            end
            enable      = ($urandom_range(0, 9) != 0);
            up          = 1'($urandom_range(0, 1));
            down        = 1'($urandom_range(0, 1));
            step        = 4'($urandom_range(0, 15));
            load        = ($urandom_range(0, 9) == 0);
            load_value  = 8'($urandom_range(0, 255));
            clear_flags = ($urandom_range(0, 5) == 0);
            cycle("rand");
        end

        // Reset mid-run beats load and step.
        reset = 1'b1; load = 1'b1; load_value = 8'd33; enable = 1'b1; up = 1'b1; down = 1'b0;
        clear_flags = 1'b0;
        cycle("t5_reset");
        chk("t5_count", 32'({cnt[0], cnt[1]}), 32'({8'd0, 8'd250}));
        chk("t5_flags", 32'({ovp[0], unp[0], ovs[0], uns[0], ovp[1], unp[1], ovs[1], uns[1]}), 32'd0);
        reset = 1'b0; load = 1'b0; enable = 1'b0;
        cycle("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
